// File: rtl/ram_ctrl_pkg.sv
// Shared types for the RAM controller: FSM states, operation encoding and wait-counter width.
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // Wide enough for the full 0..15 wait-state range.
    localparam int CNT_W = 4;

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM with registered read data and no reset.
module ram_sp #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read-first: dout reflects the contents before a same-edge write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/ram_ctrl.sv
// Data-RAM sequencer feeding the MDR: single-word reads/writes with WAIT_STATES extra cycles.
// Optional read parity checking is enabled with the RAM_CTRL_PARITY_EN macro.
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int MAX_WIDTH   = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] busADDR,
    input  logic [MAX_WIDTH-1:0]  busDATA_OUT,
    output logic [MAX_WIDTH-1:0]  busRAM,
    output logic                  busy,
    output logic                  done
`ifdef RAM_CTRL_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

`ifdef RAM_CTRL_PARITY_EN
    localparam int MEM_W = MAX_WIDTH + 1;
`else
    localparam int MEM_W = MAX_WIDTH;
`endif

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    op_t                   op;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [MAX_WIDTH-1:0]  data_q;

    logic                  req;
    logic                  commit;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [MEM_W-1:0]      ram_din;
    logic [MEM_W-1:0]      ram_dout;

    assign req    = rd_req | wr_req;
    assign commit = (state == ACCESS) && (cnt == '0);

    // The array is addressed by the latched address from the request edge onward, so its
    // registered output already holds mem[addr_q] when the commit edge arrives.
    assign ram_addr = (state == IDLE) ? busADDR : addr_q;
    // Gated by rst because the array itself has no reset.
    assign ram_we   = commit && (op == OP_WR) && rst;

`ifdef RAM_CTRL_PARITY_EN
    assign ram_din = {^data_q, data_q};
`else
    assign ram_din = data_q;
`endif

    ram_sp #(
        .WIDTH (MEM_W),
        .DEPTH (2 ** ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_dout)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = CNT_W'(WAIT_STATES);
                end
            end
            ACCESS: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            busRAM <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req) begin
                addr_q <= busADDR;
                data_q <= busDATA_OUT;
                op     <= wr_req ? OP_WR : OP_RD;
            end
            if (commit && op == OP_RD) begin
                busRAM <= ram_dout[MAX_WIDTH-1:0];
            end
        end
    end

`ifdef RAM_CTRL_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            parity_err <= 1'b0;
        end else if (commit && op == OP_RD) begin
            parity_err <= ram_dout[MAX_WIDTH] ^ (^ram_dout[MAX_WIDTH-1:0]);
        end
    end
`endif

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed scoreboard bench for ram_ctrl; define RAM_CTRL_PARITY_EN to include the parity case.
module tb_ram_ctrl;

    localparam int WS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rd_req = 1'b0;
    logic       wr_req = 1'b0;
    logic [7:0] busADDR = '0;
    logic [7:0] busDATA_OUT = '0;
    logic [7:0] busRAM;
    logic       busy;
    logic       done;
`ifdef RAM_CTRL_PARITY_EN
    logic       parity_err;
`endif

    int vectors = 0;
    int errors  = 0;

    // Expected {parity_err, busRAM} at each done pulse.
    logic [8:0] exp_q[$];

    ram_ctrl #(
        .MAX_WIDTH   (8),
        .ADDR_WIDTH  (8),
        .WAIT_STATES (WS)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .busADDR     (busADDR),
        .busDATA_OUT (busDATA_OUT),
        .busRAM      (busRAM),
        .busy        (busy),
        .done        (done)
`ifdef RAM_CTRL_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("done_busRAM", 32'(busRAM), 32'(e[7:0]));
`ifdef RAM_CTRL_PARITY_EN
                check("done_parity_err", 32'(parity_err), 32'(e[8]));
`endif
            end
        end
    end

    // Issues one request, scrambles the bus after the request edge, and checks the
    // busy/done window. hold_rd keeps rd_req high during the busy cycles.
    task automatic run_txn(input logic r, input logic w, input logic [7:0] a,
                           input logic [7:0] d, input logic [8:0] exp, input logic hold_rd);
        exp_q.push_back(exp);
        @(negedge clk);
        rd_req = r; wr_req = w; busADDR = a; busDATA_OUT = d;
        @(negedge clk);
        rd_req = hold_rd; wr_req = 1'b0; busADDR = ~a; busDATA_OUT = ~d;
        for (int i = 1; i <= WS + 3; i++) begin
            if (i > 1) @(negedge clk);
            if (i == WS + 1) rd_req = 1'b0;
            check($sformatf("busy_c%0d", i), 32'(busy), 32'(i <= WS + 2));
            check($sformatf("done_c%0d", i), 32'(done), 32'(i == WS + 2));
        end
    endtask

    initial begin
        logic [7:0] last;
        logic       lperr;
        last = 8'h00;
        lperr = 1'b0;

        // Reset with a pending read: nothing may start.
        rd_req = 1'b1;
        busADDR = 8'h05;
        repeat (2) begin
            @(negedge clk);
            check("rst_busRAM", 32'(busRAM), 32'h0);
            check("rst_busy", 32'(busy), 32'h0);
            check("rst_done", 32'(done), 32'h0);
        end
        rd_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'h0);

        // Write, then read back.
        run_txn(1'b0, 1'b1, 8'h05, 8'hF0, {lperr, last}, 1'b0);
        check("wr_busRAM_hold", 32'(busRAM), 32'h00);
        run_txn(1'b1, 1'b0, 8'h05, 8'h00, {1'b0, 8'hF0}, 1'b0);
        last = 8'hF0; lperr = 1'b0;
        @(negedge clk);
        check("rd_busRAM_hold", 32'(busRAM), 32'hF0);

        // Both requests: write wins; a read held during busy is ignored.
        run_txn(1'b1, 1'b1, 8'h06, 8'h0F, {lperr, last}, 1'b1);
        check("both_busRAM_hold", 32'(busRAM), 32'hF0);
        run_txn(1'b1, 1'b0, 8'h06, 8'h00, {1'b0, 8'h0F}, 1'b0);
        last = 8'h0F;

        // Preload 0x07, then abort a write to it with reset.
        run_txn(1'b0, 1'b1, 8'h07, 8'h11, {lperr, last}, 1'b0);
        @(negedge clk);
        wr_req = 1'b1; busADDR = 8'h07; busDATA_OUT = 8'hAA;
        @(negedge clk);
        wr_req = 1'b0; rst = 1'b0;
        check("abort_busy_pre", 32'(busy), 32'h1);
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_busRAM", 32'(busRAM), 32'h00);
        rst = 1'b1;
        last = 8'h00; lperr = 1'b0;
        repeat (WS + 3) @(negedge clk);
        check("abort_idle_busy", 32'(busy), 32'h0);
        run_txn(1'b1, 1'b0, 8'h07, 8'h00, {1'b0, 8'h11}, 1'b0);
        last = 8'h11;

`ifdef RAM_CTRL_PARITY_EN
        run_txn(1'b0, 1'b1, 8'h09, 8'h3C, {lperr, last}, 1'b0);
        u_dut.u_ram.mem[9] = {1'b1, 8'h3C};
        run_txn(1'b1, 1'b0, 8'h09, 8'h00, {1'b1, 8'h3C}, 1'b0);
        run_txn(1'b1, 1'b0, 8'h05, 8'h00, {1'b0, 8'hF0}, 1'b0);
`endif

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
